mem_request_port: RTL and testbench

Core-side requester for the shared-memory arbiter. One instance sits between each tinyGPU core's load/store path and one arbiter request channel (en0..en3).
- Accepts one load/store from the core.
- Raises en with rw/addr/wdata held stable, waits for the arbiter's mready, captures read data, and returns a one-cycle response to the core.
- Exactly one transaction outstanding at a time.

---
 rtl/mem_request_port_if.sv | 35 +++
 rtl/mem_request_port.sv | 143 ++++++++++++++
 tb/tb_mem_request_port.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_request_port_if.sv
// Core-side and arbiter-side signal bundle for mem_request_port.
// master = the request port itself, slave = core plus arbiter environment.
interface mem_request_port_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  en;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata,
        input  mready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output en, rw, addr, wdata
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata,
        output mready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  en, rw, addr, wdata
    );
endinterface

// File: rtl/mem_request_port.sv
// Single-outstanding load/store requester for one shared-memory arbiter channel.
// Optional arbiter timeout is enabled with the MEM_TIMEOUT_EN macro.
module mem_request_port #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clock,
    input  logic               reset,
    mem_request_port_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_timeout;
    logic                  w_tmo_hit;
    logic                  r_req_ready;
    logic                  r_en;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count REQ cycles spent waiting on the arbiter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ && !bus.mready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Last waiting cycle: the counter reaches the limit on this edge
    assign w_tmo_hit = (r_cnt == CNT_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state decode; mready has priority over the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_ready  <= 1'b1;
            r_en         <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_en         <= (w_state_nxt == S_REQ);
            r_resp_valid <= (w_state_nxt == S_RESP);
        end
    end

    // Request latch and response capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rw       <= bus.req_rw;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_resp_err <= 1'b0;
            end
            if (w_capture) begin
                r_resp_rdata <= r_rw ? '0 : bus.mem_rdata;
                r_resp_err   <= 1'b0;
            end
            if (w_timeout) begin
                r_resp_rdata <= '0;
                r_resp_err   <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.en         = r_en;
    assign bus.rw         = r_rw;
    assign bus.addr       = r_addr;
    assign bus.wdata      = r_wdata;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_mem_request_port.sv
// Scoreboard bench for mem_request_port with a behavioural arbiter.
// Build with MEM_TIMEOUT_EN defined to cover the timeout path.
module tb_mem_request_port;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 4;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         at;
    } exp_t;

    typedef struct {
        int         stall;
        logic [7:0] mval;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         len;
        logic       chk_len;
    } arb_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    bit         stray = 1'b0;
    logic [7:0] last_rdata = 8'h00;
    exp_t       sb[$];
    arb_t       aq[$];

    mem_request_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_request_port #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arbiter model: grants after cur.stall en cycles, checks held fields
    initial begin
        arb_t cur;
        int   age;
        bit   act;
        age = 0;
        act = 1'b0;
        cur.stall = 0; cur.mval = 8'h00; cur.rw = 1'b0; cur.addr = 8'h00;
        cur.wdata = 8'h00; cur.len = 0; cur.chk_len = 1'b0;
        bus.mready    = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clock);
            if (bus.en) begin
                if (!act) begin
                    check("arb_entry", 32'(aq.size() != 0), 1);
                    if (aq.size() != 0) cur = aq.pop_front();
                    act = 1'b1;
                    age = 0;
                end
                check("en_rw", bus.rw, cur.rw);
                check("en_addr", bus.addr, cur.addr);
                check("en_wdata", bus.wdata, cur.wdata);
                check("err_in_req", bus.resp_err, 0);
                bus.mready    = (age == cur.stall);
                bus.mem_rdata = (age == cur.stall) ? cur.mval : 8'($urandom);
                age++;
            end else begin
                if (act && cur.chk_len) check("en_len", age, cur.len);
                act = 1'b0;
                bus.mready    = stray && ($urandom_range(0, 1) == 1);
                bus.mem_rdata = 8'($urandom);
            end
        end
    end

    // Response monitor: pops the scoreboard on every resp_valid
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.resp_valid) begin
                check("resp_pulse", prev, 0);
                check("resp_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_rdata", bus.resp_rdata, e.rdata);
                    check("resp_err", bus.resp_err, e.err);
                    check("resp_cycle", cyc, e.at);
                    last_rdata = e.rdata;
                end
            end
            prev = bus.resp_valid;
        end
    end

    // Present a request at a negedge; returns at the negedge after accept
    task automatic issue(input logic rw, input logic [7:0] addr,
                         input logic [7:0] wdata, input int stall,
                         input logic [7:0] mval, input bit drop,
                         output int acc);
        exp_t e;
        arb_t a;
        bit   tmo;
        int   n;
        tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
        tmo = (stall >= TMO);
`endif
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("accept_wait", bus.req_ready, 1);
        acc       = cyc;
        e.rdata   = (tmo || rw) ? 8'h00 : mval;
        e.err     = tmo;
        e.at      = cyc + 2 + (tmo ? TMO - 1 : stall);
        a.stall   = stall;
        a.mval    = mval;
        a.rw      = rw;
        a.addr    = addr;
        a.wdata   = wdata;
        a.len     = tmo ? TMO : stall + 1;
        a.chk_len = !drop;
        if (!drop) sb.push_back(e);
        aq.push_back(a);
        @(negedge clock);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, a0, a1, a2;
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_en", bus.en, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_err", bus.resp_err, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_wdata", bus.wdata, 0);
        reset = 1'b0;
        stray = 1'b1;
        @(negedge clock);

        issue(1'b0, 8'h12, 8'h00, 0, 8'hA5, 1'b0, acc);
        bus.req_valid = 1'b0;
        wait_idle();

        issue(1'b1, 8'h34, 8'h5A, 7, 8'hEE, 1'b0, acc);
        bus.req_valid = 1'b0;
        wait_idle();

        issue(1'b0, 8'h40, 8'h00, 0, 8'h11, 1'b0, a0);
        issue(1'b1, 8'h41, 8'h22, 0, 8'h99, 1'b0, a1);
        issue(1'b0, 8'h42, 8'h00, 0, 8'h33, 1'b0, a2);
        bus.req_valid = 1'b0;
        check("b2b_gap1", a1 - a0, 3);
        check("b2b_gap2", a2 - a1, 3);
        wait_idle();

        issue(1'b0, 8'h55, 8'h00, 10, 8'h77, 1'b1, acc);
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_en", bus.en, 0);
        check("midrst_ready", bus.req_ready, 1);
        check("midrst_resp", bus.resp_valid, 0);
        check("midrst_rdata", bus.resp_rdata, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        issue(1'b0, 8'h66, 8'h00, 2, 8'hC8, 1'b0, acc);
        bus.req_valid = 1'b0;
        wait_idle();

`ifdef MEM_TIMEOUT_EN
        issue(1'b0, 8'h70, 8'h00, 1000, 8'hBB, 1'b0, acc);
        bus.req_valid = 1'b0;
        wait_idle();
        issue(1'b0, 8'h71, 8'h00, TMO - 1, 8'hC3, 1'b0, acc);
        bus.req_valid = 1'b0;
        wait_idle();
`endif

        issue(1'b0, 8'h80, 8'h00, 200, 8'h3C, 1'b0, acc);
        bus.req_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clock);
        check("rdata_hold", bus.resp_rdata, last_rdata);
        check("final_idle", bus.req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
